// File: rtl/mode7_param_ctrl.sv
// Mode7 parameter controller: shadow bank written by host/buttons, copied to the active bank during vblank.
// Latency: host write acked 1 cycle after request in IDLE; commit_done pulses 11 cycles after the vblank rise.
// Backpressure: host requests stall (no ack) outside IDLE; the one-entry button slot drops pulses while full.
// Optional build: define ANGLE_WRAP_EN to wrap every shadow angle update into [0, 360.0).
module mode7_param_ctrl #(
    parameter logic [23:0] STEP      = 24'h000100,
    parameter logic [23:0] ANIM_STEP = 24'h000080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vblank,
    input  logic [3:0]  sel,
    input  logic        inc_pulse,
    input  logic        dec_pulse,
    input  logic        wr_req,
    input  logic [3:0]  wr_addr,
    input  logic [23:0] wr_data,
    output logic        wr_ack,
    input  logic        anim_en,
    output logic [23:0] offsetx,
    output logic [23:0] offsety,
    output logic [23:0] originx,
    output logic [23:0] originy,
    output logic [23:0] texturew,
    output logic [23:0] textureh,
    output logic [23:0] scalex,
    output logic [23:0] scaley,
    output logic [23:0] angle,
    output logic        busy,
    output logic        commit_done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ANIM   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] IDX_LAST  = 4'd8;
    localparam logic [3:0] IDX_ANGLE = 4'd8;

    // Element 8 (angle) first, element 0 (offsetx) last.
    localparam logic [8:0][23:0] RST_BANK = {
        24'h000000, 24'h000100, 24'h000100, 24'h004000, 24'h004000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000
    };

`ifdef ANGLE_WRAP_EN
    localparam logic [23:0] ANGLE_MAX = 24'h016800;

    function automatic logic [23:0] f_ang_up(input logic [23:0] a, input logic [23:0] d);
        logic [23:0] s;
        s = a + d;
        return (s >= ANGLE_MAX) ? (s - ANGLE_MAX) : s;
    endfunction

    function automatic logic [23:0] f_ang_dn(input logic [23:0] a, input logic [23:0] d);
        return (a < d) ? (a + ANGLE_MAX - d) : (a - d);
    endfunction

    function automatic logic [23:0] f_ang_host(input logic [23:0] d);
        return (d >= ANGLE_MAX) ? (d - ANGLE_MAX) : d;
    endfunction
`else
    function automatic logic [23:0] f_ang_up(input logic [23:0] a, input logic [23:0] d);
        return a + d;
    endfunction

    function automatic logic [23:0] f_ang_dn(input logic [23:0] a, input logic [23:0] d);
        return a - d;
    endfunction

    function automatic logic [23:0] f_ang_host(input logic [23:0] d);
        return d;
    endfunction
`endif

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [3:0]       r_cnt;
    logic             r_vblank_q;
    logic             r_wr_ack;
    logic             r_pend_vld;
    logic             r_pend_dir;   // 1 = decrement
    logic [3:0]       r_pend_sel;
    logic [8:0][23:0] r_shadow;
    logic [8:0][23:0] r_active;

    logic             w_vb_rise;
    logic             w_host_acc;
    logic             w_btn_apply;
    logic             w_anim_upd;
    logic             w_pulse_ok;
    logic [23:0]      w_cur;
    logic             w_sh_we;
    logic [3:0]       w_sh_idx;
    logic [23:0]      w_sh_dat;

    assign w_vb_rise   = vblank & ~r_vblank_q;
    // An accepted host write includes out-of-range addresses: they still consume the cycle and get acked.
    assign w_host_acc  = (r_state == S_IDLE) && wr_req && !r_wr_ack;
    assign w_btn_apply = (r_state == S_IDLE) && r_pend_vld && !w_host_acc;
    assign w_anim_upd  = (r_state == S_ANIM) && anim_en;
    assign w_pulse_ok  = (inc_pulse ^ dec_pulse) && (sel <= IDX_LAST);
    assign w_cur       = r_shadow[r_pend_sel];

    // Pick the single shadow write for this cycle: host, then pending button, then animation.
    always_comb begin
        w_sh_we  = 1'b0;
        w_sh_idx = 4'd0;
        w_sh_dat = 24'd0;
        if (w_host_acc) begin
            if (wr_addr <= IDX_LAST) begin
                w_sh_we  = 1'b1;
                w_sh_idx = wr_addr;
                w_sh_dat = (wr_addr == IDX_ANGLE) ? f_ang_host(wr_data) : wr_data;
            end
        end else if (w_btn_apply) begin
            w_sh_we  = 1'b1;
            w_sh_idx = r_pend_sel;
            if (r_pend_sel == IDX_ANGLE) begin
                w_sh_dat = r_pend_dir ? f_ang_dn(w_cur, STEP) : f_ang_up(w_cur, STEP);
            end else begin
                w_sh_dat = r_pend_dir ? (w_cur - STEP) : (w_cur + STEP);
            end
        end else if (w_anim_upd) begin
            w_sh_we  = 1'b1;
            w_sh_idx = IDX_ANGLE;
            w_sh_dat = f_ang_up(r_shadow[IDX_ANGLE], ANIM_STEP);
        end
    end

    // Next-state logic: vblank rises only start a commit from IDLE; edges seen while busy are dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_vb_rise) w_state_nxt = S_ANIM;
            S_ANIM:   w_state_nxt = S_COMMIT;
            S_COMMIT: if (r_cnt == IDX_LAST) w_state_nxt = S_DONE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State register, commit index and vblank edge history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_vblank_q <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_vblank_q <= vblank;
            r_cnt      <= (r_state == S_COMMIT) ? (r_cnt + 4'd1) : 4'd0;
        end
    end

    // Host acknowledge follows an accepted request by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ack <= 1'b0;
        end else begin
            r_wr_ack <= w_host_acc;
        end
    end

    // One-entry button slot: fills only when empty, clears when its update lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_vld <= 1'b0;
            r_pend_dir <= 1'b0;
            r_pend_sel <= 4'd0;
        end else begin
            if (w_btn_apply) begin
                r_pend_vld <= 1'b0;
            end
            if (!r_pend_vld && w_pulse_ok) begin
                r_pend_vld <= 1'b1;
                r_pend_dir <= dec_pulse;
                r_pend_sel <= sel;
            end
        end
    end

    // Shadow bank write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= RST_BANK;
        end else if (w_sh_we) begin
            r_shadow[w_sh_idx] <= w_sh_dat;
        end
    end

    // Active bank: one parameter copied per COMMIT cycle, index = commit cycle number.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= RST_BANK;
        end else if (r_state == S_COMMIT) begin
            r_active[r_cnt] <= r_shadow[r_cnt];
        end
    end

    assign wr_ack      = r_wr_ack;
    assign busy        = (r_state != S_IDLE);
    assign commit_done = (r_state == S_DONE);

    assign offsetx  = r_active[0];
    assign offsety  = r_active[1];
    assign originx  = r_active[2];
    assign originy  = r_active[3];
    assign texturew = r_active[4];
    assign textureh = r_active[5];
    assign scalex   = r_active[6];
    assign scaley   = r_active[7];
    assign angle    = r_active[8];

endmodule

// File: doc/mode7_param_ctrl.md
# mode7_param_ctrl

Parameter controller for the Mode7 renderer. Holds a shadow bank of the nine 24-bit 16.8 fixed-point transform parameters and arbitrates writes to it between a host write port and the manual inc/dec buttons. Applies an optional per-frame angle animation and commits the shadow bank to the active outputs during vertical blank, so the renderer never sees a parameter change mid-frame.

## Interface
Parameters:
- STEP, 24'h000100, button increment/decrement amount (1.0).
- ANIM_STEP, 24'h000080, angle added per frame when animation is enabled (0.5).

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- vblank  in  1  vertical-blank level, synchronous to clk.
- sel  in  4  parameter index for buttons: 0 offsetx, 1 offsety, 2 originx, 3 originy, 4 texturew, 5 textureh, 6 scalex, 7 scaley, 8 angle.
- inc_pulse  in  1  one-cycle pulse from the debounced plus button.
- dec_pulse  in  1  one-cycle pulse from the debounced minus button.
- wr_req  in  1  host write request; held until wr_ack.
- wr_addr  in  4  host write index, same map as sel.
- wr_data  in  24  host write data.
- wr_ack  out  1  one-cycle write acknowledge.
- anim_en  in  1  enables per-frame angle animation.
- offsetx, offsety, originx, originy, texturew, textureh, scalex, scaley, angle  out  24 each  active parameters.
- busy  out  1  high in every state except IDLE.
- commit_done  out  1  one-cycle pulse after a commit completes.

## Operation
- Reset values for the shadow and active banks: indices 0–3 = 0, texturew = textureh = 24'h004000 (64.0), scalex = scaley = 24'h000100 (1.0), angle = 0. wr_ack, busy and commit_done are 0. FSM is in IDLE. The pending slot is empty.
- FSM: IDLE -> ANIM on a vblank rising edge (registered vblank_q). ANIM -> COMMIT after 1 cycle. COMMIT lasts 9 cycles, copying shadow[i] to active[i] in cycle i (i = 0..8). It then goes to DONE for 1 cycle with commit_done = 1, then back to IDLE.
- ANIM: if anim_en = 1, shadow angle += ANIM_STEP. Otherwise no change.
- Button pending slot: one entry, {dir, sel}.
  - A pulse when the slot is empty captures dir and the current sel.
  - A pulse when the slot is full is dropped.
  - inc_pulse and dec_pulse in the same cycle are both dropped.
  - A pulse with sel > 8 is dropped.
- Arbitration, IDLE only, one shadow write per cycle:
  - Host write wins over the pending button.
  - The pending button entry applies in a cycle with no accepted host write, then the slot clears.
- Host handshake:
  - In IDLE, with wr_req = 1 and wr_ack = 0, the shadow is written at the clock edge and wr_ack = 1 in the next cycle.
  - No write is accepted in a cycle where wr_ack = 1.
  - wr_addr > 8 is acked but writes nothing.
- Arithmetic: two's complement, modulo 2^24. Increment is value + STEP; decrement is value − STEP.
- In ANIM, COMMIT and DONE: host requests are stalled (no ack). Button pulses may still fill the slot.
- A vblank rising edge while not in IDLE is ignored; no commit is queued.

## Timing
- Active outputs change only in COMMIT cycles. A shadow write becomes visible at the next commit, 2 to 10 cycles after that commit's vblank rising edge.
- Host write latency is 1 cycle (request to ack) when IDLE. A button update is applied to the shadow by the earliest IDLE cycle without an accepted host write, at or after the cycle following the pulse.
- Asserting reset mid-COMMIT immediately restores all reset values and returns the FSM to IDLE. A partially copied active bank is overwritten by reset values.

## Configuration
- ANGLE_WRAP_EN defined: every shadow angle update (host, button, ANIM) wraps the result into [0, 24'h016800), i.e. 0–360.0.
  - A result ≥ 24'h016800 has 24'h016800 subtracted.
  - A decrement result below 0 has 24'h016800 added.
  - Host writes ≥ 24'h016800 are reduced by one subtraction.
- ANGLE_WRAP_EN undefined: angle uses plain modulo-2^24 arithmetic like the other parameters.

## Test plan
- Reset, then run one vblank -> all outputs at the reset values above, commit_done pulses exactly once, 11 cycles after the rising edge.
- Host write addr 6 data 24'h000200, then vblank -> wr_ack 1 cycle later; scalex stays 24'h000100 until COMMIT cycle 6, then reads 24'h000200.
- wr_req (addr 0, 24'h000500) and inc_pulse (sel 0) in the same IDLE cycle -> host write first, button applied next free cycle; after commit offsetx = 24'h000600.
- dec_pulse with sel 1 from reset, then commit -> offsety = 24'hFFFF00. Simultaneous inc+dec -> no change. A second pulse while the slot is full -> dropped.
- anim_en = 1, angle = 24'h0167C0, one vblank -> with ANGLE_WRAP_EN angle = 24'h000040; without it angle = 24'h016840.
- wr_req asserted during COMMIT -> no ack until DONE→IDLE, then ack; assert reset mid-COMMIT -> outputs return to reset values and busy = 0.
